// File: rtl/array_cmd_if.sv
// array_cmd_if: command/response handshake bundle for array_cmd_fsm.
// The slave modport is the array engine; the master modport is whoever
// issues commands and consumes responses.
interface array_cmd_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              done;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, done
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, done
    );
endinterface

// File: rtl/array_cmd_fsm.sv
// array_cmd_fsm: small register array driven by a command FSM
// (IDLE -> EXEC -> RESP -> IDLE, halt parks in END until reset).
// Operations: 00 write, 01 read, 10 add (wrapping), 11 halt.
// Addresses >= DEPTH never touch the array and always get an error response.
// Optional build macro: ARRAY_CMD_WRITE_ACK_EN -- when defined, error-free
// writes also produce a response (rsp_data = written value); otherwise they
// are posted and return straight to IDLE.
// ADDR_W is expected to be <= 32 and wide enough to index DEPTH words.
module array_cmd_fsm #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    array_cmd_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10,
        END  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_ADD   = 2'b10,
        OP_HALT  = 2'b11
    } op_t;

    // True when the address selects a physically present word.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return (32'(a) < 32'(DEPTH));
    endfunction

    state_t            state_r;
    state_t            state_nx_s;
    op_t               op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              cmd_ready_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_data_r;
    logic              rsp_err_r;
    logic              done_r;

    logic              cmd_ready_nx_s;
    logic              rsp_valid_nx_s;
    logic [DATA_W-1:0] rsp_data_nx_s;
    logic              rsp_err_nx_s;
    logic              done_nx_s;

    logic              accept_s;
    logic              mem_we_s;
    logic [DEPTH-1:0]  hit_s;
    logic [DATA_W-1:0] old_word_s;
    logic [DATA_W-1:0] sum_s;
    logic              addr_ok_s;
    logic              wr_en_s;
    logic [DATA_W-1:0] wr_word_s;
    logic [DATA_W-1:0] exec_rsp_data_s;
    logic              need_rsp_s;

    // Word decode and read mux for the latched address.
    always_comb begin
        hit_s      = '0;
        old_word_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_s[i]   = (32'(addr_r) == 32'(i));
            old_word_s = old_word_s | (mem_r[i] & {DATA_W{hit_s[i]}});
        end
    end

    assign addr_ok_s = addr_in_range(addr_r);
    assign sum_s     = old_word_s + data_r;

    // Per-operation outcome of the EXEC cycle: what to store and what to answer.
    always_comb begin
        wr_en_s         = 1'b0;
        wr_word_s       = data_r;
        exec_rsp_data_s = '0;
        need_rsp_s      = 1'b1;
        case (op_r)
            OP_WRITE: begin
                wr_en_s         = addr_ok_s;
                wr_word_s       = data_r;
                exec_rsp_data_s = addr_ok_s ? data_r : '0;
`ifdef ARRAY_CMD_WRITE_ACK_EN
                need_rsp_s      = 1'b1;
`else
                need_rsp_s      = !addr_ok_s;
`endif
            end
            OP_READ: begin
                wr_en_s         = 1'b0;
                exec_rsp_data_s = addr_ok_s ? old_word_s : '0;
            end
            OP_ADD: begin
                wr_en_s         = addr_ok_s;
                wr_word_s       = sum_s;
                exec_rsp_data_s = addr_ok_s ? sum_s : '0;
            end
            default: begin
                // Halt never reaches EXEC; nothing to do.
                need_rsp_s      = 1'b0;
            end
        endcase
    end

    // Next-state and next-output decode for the command FSM.
    always_comb begin
        state_nx_s     = state_r;
        accept_s       = 1'b0;
        mem_we_s       = 1'b0;
        rsp_valid_nx_s = rsp_valid_r;
        rsp_data_nx_s  = rsp_data_r;
        rsp_err_nx_s   = rsp_err_r;
        case (state_r)
            IDLE: begin
                accept_s = bus.cmd_valid && cmd_ready_r;
                if (accept_s) begin
                    if (op_t'(bus.cmd_op) == OP_HALT) begin
                        state_nx_s = END;
                    end else begin
                        state_nx_s = EXEC;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            EXEC: begin
                mem_we_s = wr_en_s;
                if (need_rsp_s) begin
                    state_nx_s     = RESP;
                    rsp_valid_nx_s = 1'b1;
                    rsp_data_nx_s  = exec_rsp_data_s;
                    rsp_err_nx_s   = !addr_ok_s;
                end else begin
                    state_nx_s     = IDLE;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nx_s     = IDLE;
                    rsp_valid_nx_s = 1'b0;
                end else begin
                    state_nx_s     = RESP;
                end
            end
            END: begin
                state_nx_s = END;
            end
            default: begin
                state_nx_s     = IDLE;
                rsp_valid_nx_s = 1'b0;
            end
        endcase
        cmd_ready_nx_s = (state_nx_s == IDLE);
        done_nx_s      = (state_nx_s == END);
    end

    // State register and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cmd_ready_r <= cmd_ready_nx_s;
            rsp_valid_r <= rsp_valid_nx_s;
            rsp_data_r  <= rsp_data_nx_s;
            rsp_err_r   <= rsp_err_nx_s;
            done_r      <= done_nx_s;
        end
    end

    // Command capture on the accept edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r   <= OP_WRITE;
            addr_r <= '0;
            data_r <= '0;
        end else if (accept_s) begin
            op_r   <= op_t'(bus.cmd_op);
            addr_r <= bus.cmd_addr;
            data_r <= bus.cmd_data;
        end else begin
            op_r   <= op_r;
            addr_r <= addr_r;
            data_r <= data_r;
        end
    end

    // Array storage: cleared by reset, one word written per EXEC cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_we_s && hit_s[i]) begin
                    mem_r[i] <= wr_word_s;
                end else begin
                    mem_r[i] <= mem_r[i];
                end
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.done      = done_r;

endmodule

// File: doc/array_cmd_fsm.md
ARRAY_CMD_FSM -- requirements
Module: array_cmd_fsm

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning array word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of array words (2..256).
REQ-003 SHALL have parameter ADDR_W, default 8, meaning command address width in bits.
REQ-004 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-008 SHALL have port cmd_op  input  2  00 write, 01 read, 10 add, 11 halt.
REQ-009 SHALL have port cmd_addr  input  ADDR_W  word index.
REQ-010 SHALL have port cmd_data  input  DATA_W  write data or addend.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-013 SHALL have port rsp_data  output  DATA_W  read value or post-add value.
REQ-014 SHALL have port rsp_err  output  1  command addressed a word >= DEPTH.
REQ-015 SHALL have port done  output  1  halt executed; block parked.

Function
REQ-016 SHALL implement states IDLE, EXEC, RESP, END.
REQ-017 SHALL drive cmd_ready high only in IDLE.
REQ-018 SHALL latch op, addr and data on a cmd_valid&cmd_ready edge and move IDLE->EXEC; halt moves IDLE->END directly.
REQ-019 SHALL, in EXEC, perform the array access in one cycle: write stores cmd_data; add stores (old + cmd_data) mod 2^DATA_W; read leaves the array unchanged.
REQ-020 SHALL, for addr >= DEPTH, leave the array unchanged, force rsp_err=1 and rsp_data=0, and respond for every op type, including write.
REQ-021 SHALL move EXEC->RESP for read, add and errored commands, and EXEC->IDLE for error-free writes (see REQ-029).
REQ-022 SHALL hold rsp_valid, rsp_data and rsp_err stable in RESP until rsp_ready is high, then return to IDLE on that edge.
REQ-023 SHALL return on add the post-add stored value, and on read the word value at EXEC.
REQ-024 SHALL give latency from accept edge to rsp_valid of exactly 2 cycles when rsp_ready is held high.
REQ-025 SHALL allow back-to-back commands: the next command is accepted no earlier than the cycle after the previous returns to IDLE.
REQ-026 SHALL, in END, hold done=1 and cmd_ready=0, and ignore all inputs until reset.

Reset
REQ-027 SHALL, while reset is low, force state IDLE, all array words 0, rsp_valid 0, rsp_data 0, rsp_err 0 and done 0, with cmd_ready following as 1 (IDLE).
REQ-028 SHALL abort any command in EXEC or RESP on reset assertion without updating the array or issuing a response after release.

Configuration
REQ-029 SHALL, with macro ARRAY_CMD_WRITE_ACK_EN defined, route error-free writes through RESP with rsp_data = written value and rsp_err=0; without it, such writes are posted (no response).

Verification
REQ-030 SHALL cover: write addr 3 data 0x123, then read addr 3 -> rsp_valid 2 cycles after read accept, rsp_data=0x00000123, rsp_err=0.
REQ-031 SHALL cover: write addr 1 0xFFFFFFFF, add addr 1 data 2 -> rsp_data=0x00000001, and a subsequent read of addr 1 returns 1.
REQ-032 SHALL cover: read addr 4 with DEPTH=4 -> rsp_err=1, rsp_data=0; write addr 7 -> error response, array contents unchanged.
REQ-033 SHALL cover: read with rsp_ready low for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0 throughout, IDLE one cycle after rsp_ready rises.
REQ-034 SHALL cover: halt -> done=1 next cycle, cmd_ready=0; further commands are ignored; reset low restores done=0 and all words read 0.
REQ-035 SHALL cover: reset asserted during RESP of a read -> rsp_valid=0 immediately and no response after release; with and without ARRAY_CMD_WRITE_ACK_EN, write count of responses is checked.
